raw_atom_sched: RTL and testbench
=================================

// Module: raw_atom_sched
// PURPOSE
//  Shares one read-add-write (RAW) stateful atom between NUM_REQ packet requesters.
//  - Round-robin grants at most one request per cycle; the block owns the atom register.
//  - Returns the pre-update (read) and post-update (write) values to the winner.
//  - Sequences runtime reconfiguration of constant/sel1/sel2 safely around in-flight ops.
// PARAMETERS
//  COUNT_WIDTH  32  width of atom register, constant and packet fields
//  NUM_REQ      4   number of requesters (>=2)
//  ID_WIDTH     2   width of requester index, = clog2(NUM_REQ)
// PORTS
//  clk              in   1                    clock, all state on posedge
//  rst              in   1                    async, active-high reset
//  i__enable        in   1                    0: no new grants issued
//  i__req_valid     in   NUM_REQ              per-requester request valid
//  i__req_pkt       in   NUM_REQ*COUNT_WIDTH  packet field; slice k = requester k
//  o__req_ready     out  NUM_REQ              one-hot grant; accepted when valid&ready
//  i__cfg_valid     in   1                    reconfiguration request
//  i__cfg_constant  in   COUNT_WIDTH          new constant
//  i__cfg_sel1      in   1                    new sel1 (0: constant, 1: pkt)
//  i__cfg_sel2      in   1                    new sel2 (0: accumulate, 1: overwrite)
//  o__cfg_ready     out  1                    cfg accepted when valid&ready
//  o__resp_valid    out  1                    response strobe, 1 cycle
//  o__resp_id       out  ID_WIDTH             index of served requester
//  o__resp_read     out  COUNT_WIDTH          register value before the op
//  o__resp_write    out  COUNT_WIDTH          register value after the op
//  o__state         out  2                    FSM state encoding (below)
// BEHAVIOUR
//  - Reset: register=0, constant=0, sel1=0, sel2=0, rr pointer=0, state=RUN;
//    all outputs 0 (o__state=RUN=2'd0).
//  - Op on accept: write = (sel1 ? pkt : constant) + (sel2 ? 0 : register), mod 2^COUNT_WIDTH
//    (wraps silently, no carry); read = register; register <= write.
//  - Latency: accepted at edge N -> resp_valid/id/read/write registered, valid cycle N+1.
//    The register updates on the same edge N.
//  - Back-to-back ops each cycle; op at N+1 sees register from op at N (no hazard).
//  - No response backpressure; resp_* hold last value when resp_valid=0.
//  - Arbitration: o__req_ready combinational from i__req_valid, rr pointer, state, i__enable.
//    Search starts at pointer; pointer <= winner+1 (wrap to 0 after NUM_REQ-1) on grant only.
//    Ready never asserted to a non-valid requester; at most one bit set.
//  - FSM states: RUN=0, DRAIN=1, APPLY=2, HOLD=3.
//    RUN: grant if i__enable; i__cfg_valid=1 -> DRAIN; no grant in the cycle cfg seen.
//    DRAIN: no grants; wait 1 cycle for in-flight resp to retire -> APPLY.
//    APPLY: o__cfg_ready=1, latch cfg fields, -> RUN (or HOLD if i__enable=0).
//    HOLD: no grants; i__enable=1 -> RUN; i__cfg_valid=1 -> APPLY directly.
//    RUN with i__enable=0 and no cfg -> HOLD.
//  - i__cfg_valid must stay high until o__cfg_ready; dropping early in DRAIN returns to RUN
//    with no cfg change.
//  - cfg and req both valid in RUN: cfg wins, requests wait.
//  - Reconfiguration never alters the register value; new cfg applies from next granted op.
//  - rst mid-operation: in-flight response dropped (resp_valid=0), register and cfg reset.
// CONFIGURATION
//  RAW_ATOM_SCHED_STATS_EN defined:
//    adds output o__grant_count [32]: total accepted ops since reset.
//    Saturates at 2^32-1; cleared only by rst.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. rst, cfg const=5 sel1=0 sel2=0; req0 valid 3 cycles
//     -> resp_write 5,10,15; resp_read 0,5,10; id=0.
//  2. All 4 valid continuously
//     -> ids 0,1,2,3,0 on consecutive cycles; ready one-hot every cycle.
//  3. sel1=1 sel2=1, req2 pkt=0xFFFF_FFFF then req3 pkt=7
//     -> writes 0xFFFF_FFFF, 7; reads 0, 0xFFFF_FFFF.
//  4. sel1=1 sel2=0, register=0xFFFF_FFFE, pkt=3 -> write=1 (wrap), read=0xFFFF_FFFE.
//  5. cfg_valid while req1 streaming
//     -> grants stop, state RUN->DRAIN->APPLY->RUN; cfg_ready 1 cycle; register unchanged.
//  6. rst asserted the cycle after an accept
//     -> no resp_valid; register=0; state=RUN. With STATS_EN: grant_count=0.

Source files
------------

// File: rtl/raw_atom_sched.sv
// Round-robin scheduler sharing one read-add-write atom among NUM_REQ requesters, with safe runtime reconfig.
// Optional grant counter output when RAW_ATOM_SCHED_STATS_EN is defined.
module raw_atom_sched #(
  parameter int COUNT_WIDTH = 32,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i__enable,
  input  logic [NUM_REQ-1:0]             i__req_valid,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt,
  output logic [NUM_REQ-1:0]             o__req_ready,
  input  logic                           i__cfg_valid,
  input  logic [COUNT_WIDTH-1:0]         i__cfg_constant,
  input  logic                           i__cfg_sel1,
  input  logic                           i__cfg_sel2,
  output logic                           o__cfg_ready,
  output logic                           o__resp_valid,
  output logic [ID_WIDTH-1:0]            o__resp_id,
  output logic [COUNT_WIDTH-1:0]         o__resp_read,
  output logic [COUNT_WIDTH-1:0]         o__resp_write,
`ifdef RAW_ATOM_SCHED_STATS_EN
  output logic [31:0]                    o__grant_count,
`endif
  output logic [1:0]                     o__state
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, APPLY = 2'd2, HOLD = 2'd3} state_e;

  localparam logic [ID_WIDTH:0]   NREQ = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ-1);

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] reg_q, reg_d, const_q, operand;
  logic                   sel1_q, sel2_q;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d, win_id;
  logic [ID_WIDTH:0]      idx;
  logic                   win_any, grant;
  logic                   resp_vld_q;
  logic [ID_WIDTH-1:0]    resp_id_q;
  logic [COUNT_WIDTH-1:0] resp_read_q, resp_write_q;
  logic [COUNT_WIDTH-1:0] pkt_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt
    assign pkt_arr[g] = i__req_pkt[g*COUNT_WIDTH +: COUNT_WIDTH];
  end

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_any && i__req_valid[idx[ID_WIDTH-1:0]]) begin
        win_any = 1'b1;
        win_id  = idx[ID_WIDTH-1:0];
      end
    end
  end

  // A pending cfg blocks grants in the cycle it is first seen.
  assign grant        = (state_q == RUN) && i__enable && !i__cfg_valid && win_any;
  assign o__req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;
  assign operand      = sel1_q ? pkt_arr[win_id] : const_q;
  assign reg_d        = operand + (sel2_q ? '0 : reg_q);
  assign ptr_d        = (win_id == LAST) ? '0 : win_id + 1'b1;

  assign o__cfg_ready  = (state_q == APPLY);
  assign o__state      = state_q;
  assign o__resp_valid = resp_vld_q;
  assign o__resp_id    = resp_id_q;
  assign o__resp_read  = resp_read_q;
  assign o__resp_write = resp_write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      reg_q        <= '0;
      const_q      <= '0;
      sel1_q       <= 1'b0;
      sel2_q       <= 1'b0;
      ptr_q        <= '0;
      resp_vld_q   <= 1'b0;
      resp_id_q    <= '0;
      resp_read_q  <= '0;
      resp_write_q <= '0;
    end else begin
      resp_vld_q <= grant;
      if (grant) begin
        reg_q        <= reg_d;
        ptr_q        <= ptr_d;
        resp_id_q    <= win_id;
        resp_read_q  <= reg_q;
        resp_write_q <= reg_d;
      end
      case (state_q)
        RUN: begin
          if (i__cfg_valid)    state_q <= DRAIN;
          else if (!i__enable) state_q <= HOLD;
        end
        // One cycle lets the op granted just before the cfg retire its response.
        DRAIN: state_q <= i__cfg_valid ? APPLY : RUN;
        APPLY: begin
          if (i__cfg_valid) begin
            const_q <= i__cfg_constant;
            sel1_q  <= i__cfg_sel1;
            sel2_q  <= i__cfg_sel2;
          end
          state_q <= i__enable ? RUN : HOLD;
        end
        HOLD: begin
          if (i__cfg_valid)   state_q <= APPLY;
          else if (i__enable) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef RAW_ATOM_SCHED_STATS_EN
  logic [31:0] grant_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else if (grant && (grant_cnt_q != 32'hFFFF_FFFF)) begin
      grant_cnt_q <= grant_cnt_q + 32'd1;
    end
  end

  assign o__grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_raw_atom_sched.sv
// Scoreboard bench for raw_atom_sched: expected responses queued at drive time, popped when resp_valid strobes.
module tb_raw_atom_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  req_valid;
  logic [127:0] req_pkt;
  logic [3:0]  req_ready;
  logic        cfg_valid;
  logic [31:0] cfg_constant;
  logic        cfg_sel1, cfg_sel2;
  logic        cfg_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_read, resp_write;
  logic [1:0]  state;
`ifdef RAW_ATOM_SCHED_STATS_EN
  logic [31:0] grant_count;
`endif

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  raw_atom_sched dut (
    .clk             (clk),
    .rst             (rst),
    .i__enable       (enable),
    .i__req_valid    (req_valid),
    .i__req_pkt      (req_pkt),
    .o__req_ready    (req_ready),
    .i__cfg_valid    (cfg_valid),
    .i__cfg_constant (cfg_constant),
    .i__cfg_sel1     (cfg_sel1),
    .i__cfg_sel2     (cfg_sel2),
    .o__cfg_ready    (cfg_ready),
    .o__resp_valid   (resp_valid),
    .o__resp_id      (resp_id),
    .o__resp_read    (resp_read),
    .o__resp_write   (resp_write),
`ifdef RAW_ATOM_SCHED_STATS_EN
    .o__grant_count  (grant_count),
`endif
    .o__state        (state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] rd, input logic [31:0] wr);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.wr = wr;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] er, input logic [1:0] es, input logic ec);
    @(negedge clk);
    chk("req_ready", {60'd0, req_ready}, {60'd0, er});
    chk("state", {62'd0, state}, {62'd0, es});
    chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, ec});
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [31:0] c, input logic s1, input logic s2);
    cfg_constant = c;
    cfg_sel1     = s1;
    cfg_sel2     = s2;
    cfg_valid    = 1'b1;
    step(4'b0000, 2'd0, 1'b0);
    step(4'b0000, 2'd1, 1'b0);
    step(4'b0000, 2'd2, 1'b1);
    cfg_valid    = 1'b0;
  endtask

  task automatic set_pkt(input int k, input logic [31:0] v);
    req_pkt[k*32 +: 32] = v;
  endtask

  // Every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_id", {62'd0, resp_id}, {62'd0, e.id});
        chk("resp_read", {32'd0, resp_read}, {32'd0, e.rd});
        chk("resp_write", {32'd0, resp_write}, {32'd0, e.wr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] one;
    one          = 4'b0001;
    rst          = 1'b1;
    enable       = 1'b0;
    req_valid    = '0;
    req_pkt      = '0;
    cfg_valid    = 1'b0;
    cfg_constant = '0;
    cfg_sel1     = 1'b0;
    cfg_sel2     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_read", {32'd0, resp_read}, 64'd0);
    chk("rst_resp_write", {32'd0, resp_write}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;

    // Constant accumulate, back-to-back from one requester.
    do_cfg(32'd5, 1'b0, 1'b0);
    req_valid = 4'b0001;
    push(2'd0, 32'd0, 32'd5);   step(4'b0001, 2'd0, 1'b0);
    push(2'd0, 32'd5, 32'd10);  step(4'b0001, 2'd0, 1'b0);
    push(2'd0, 32'd10, 32'd15); step(4'b0001, 2'd0, 1'b0);
    req_valid = 4'b0000;
    step(4'b0000, 2'd0, 1'b0);

    // Round robin with all requesters valid, from a fresh pointer.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(2'(k % 4), 32'd0, 32'd0);
      step(one << (k % 4), 2'd0, 1'b0);
    end
    req_valid = 4'b0000;

    // Overwrite with packet values.
    do_cfg(32'd0, 1'b1, 1'b1);
    set_pkt(2, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    push(2'd2, 32'd0, 32'hFFFF_FFFF); step(4'b0100, 2'd0, 1'b0);
    set_pkt(3, 32'd7);
    req_valid = 4'b1000;
    push(2'd3, 32'hFFFF_FFFF, 32'd7); step(4'b1000, 2'd0, 1'b0);
    set_pkt(1, 32'hFFFF_FFFE);
    req_valid = 4'b0010;
    push(2'd1, 32'd7, 32'hFFFF_FFFE); step(4'b0010, 2'd0, 1'b0);
    req_valid = 4'b0000;

    // Packet accumulate wraps modulo 2^32.
    do_cfg(32'd0, 1'b1, 1'b0);
    set_pkt(1, 32'd3);
    req_valid = 4'b0010;
    push(2'd1, 32'hFFFF_FFFE, 32'd1); step(4'b0010, 2'd0, 1'b0);

    // Reconfig while req1 streams: grants pause, register untouched.
    set_pkt(1, 32'd2);
    push(2'd1, 32'd1, 32'd3); step(4'b0010, 2'd0, 1'b0);
    do_cfg(32'h10, 1'b0, 1'b0);
    push(2'd1, 32'd3, 32'h13); step(4'b0010, 2'd0, 1'b0);
    req_valid = 4'b0000;

    // Reset right after an accept drops the in-flight response.
    req_valid = 4'b0001;
    step(4'b0001, 2'd0, 1'b0);
    rst       = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rst_drop_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_drop_state", {62'd0, state}, 64'd0);
`ifdef RAW_ATOM_SCHED_STATS_EN
    chk("rst_grant_count", grant_count, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0001;
    push(2'd0, 32'd0, 32'd0); step(4'b0001, 2'd0, 1'b0);

    // Disable -> HOLD, cfg applied straight from HOLD.
    enable = 1'b0;
    step(4'b0000, 2'd0, 1'b0);
    step(4'b0000, 2'd3, 1'b0);
    cfg_constant = 32'd1;
    cfg_sel1     = 1'b0;
    cfg_sel2     = 1'b1;
    cfg_valid    = 1'b1;
    step(4'b0000, 2'd3, 1'b0);
    step(4'b0000, 2'd2, 1'b1);
    cfg_valid = 1'b0;
    step(4'b0000, 2'd3, 1'b0);
    enable = 1'b1;
    step(4'b0000, 2'd3, 1'b0);
    push(2'd0, 32'd0, 32'd1); step(4'b0001, 2'd0, 1'b0);

    // cfg dropped during DRAIN returns to RUN with no cfg change.
    req_valid    = 4'b0000;
    cfg_constant = 32'hAA;
    cfg_valid    = 1'b1;
    step(4'b0000, 2'd0, 1'b0);
    cfg_valid = 1'b0;
    step(4'b0000, 2'd1, 1'b0);
    req_valid = 4'b0001;
    push(2'd0, 32'd1, 32'd1); step(4'b0001, 2'd0, 1'b0);
    req_valid = 4'b0000;
    step(4'b0000, 2'd0, 1'b0);
    step(4'b0000, 2'd0, 1'b0);
`ifdef RAW_ATOM_SCHED_STATS_EN
    chk("grant_count", grant_count, 64'd3);
`endif
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
